// File: rtl/regfile_debug_port.sv
// Debug access engine for the halted core's register file: streams x0..x31 out
// (DUMP) or writes an incoming word stream into x1..x31 (LOAD).
module regfile_debug_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int REGISTER_NUM = 32,
  parameter int ADDR_WIDTH   = $clog2(REGISTER_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startDump,
  input  logic                  startLoad,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rfSrcRegister,
  input  logic [DATA_WIDTH-1:0] rfReadData,
  output logic                  rfWriteEnable,
  output logic [ADDR_WIDTH-1:0] rfDesRegister,
  output logic [DATA_WIDTH-1:0] rfWriteData,
  output logic                  dumpValid,
  input  logic                  dumpReady,
  output logic [ADDR_WIDTH-1:0] dumpIndex,
  output logic [DATA_WIDTH-1:0] dumpData,
  input  logic                  loadValid,
  output logic                  loadReady,
  input  logic [DATA_WIDTH-1:0] loadData
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DUMP_FETCH = 3'd1,
    DUMP_SEND  = 3'd2,
    LOAD       = 3'd3,
    DONE       = 3'd4
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REGISTER_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_e                  state_r;
  logic [ADDR_WIDTH-1:0]   idx_r;
  logic                    busy_r;
  logic                    done_r;
  logic [ADDR_WIDTH-1:0]   rfSrcRegister_r;
  logic                    dumpValid_r;
  logic [ADDR_WIDTH-1:0]   dumpIndex_r;
  logic [DATA_WIDTH-1:0]   dumpData_r;
  logic                    inLoad_s;
  logic                    loadBeat_s;

  // Load-state decode; the write strobe is qualified directly by the state register
  // so an async reset removes it without waiting for a clock edge.
  always_comb begin
    inLoad_s = 1'b0;
    if (state_r == LOAD) begin
      inLoad_s = 1'b1;
    end else begin
      inLoad_s = 1'b0;
    end
  end

  assign loadBeat_s = inLoad_s & loadValid;

  // RF write port and load handshake, forced to zero outside LOAD.
  always_comb begin
    loadReady     = 1'b0;
    rfWriteEnable = 1'b0;
    rfDesRegister = IDX_ZERO;
    rfWriteData   = DATA_ZERO;
    if (inLoad_s) begin
      loadReady     = 1'b1;
      rfWriteEnable = loadBeat_s;
      rfDesRegister = idx_r;
      rfWriteData   = loadData;
    end else begin
      loadReady     = 1'b0;
      rfWriteEnable = 1'b0;
    end
  end

  // Sequencer: state, register index and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      idx_r           <= IDX_ZERO;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      rfSrcRegister_r <= IDX_ZERO;
      dumpValid_r     <= 1'b0;
      dumpIndex_r     <= IDX_ZERO;
      dumpData_r      <= DATA_ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Dump has priority; a simultaneous load request is simply dropped.
          if (startDump) begin
            state_r         <= DUMP_FETCH;
            idx_r           <= IDX_ZERO;
            rfSrcRegister_r <= IDX_ZERO;
            busy_r          <= 1'b1;
          end else if (startLoad) begin
            state_r <= LOAD;
            idx_r   <= IDX_ONE;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        DUMP_FETCH: begin
          dumpData_r  <= rfReadData;
          dumpIndex_r <= idx_r;
          dumpValid_r <= 1'b1;
          state_r     <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (dumpReady) begin
            dumpValid_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              idx_r           <= idx_r + IDX_ONE;
              rfSrcRegister_r <= idx_r + IDX_ONE;
              state_r         <= DUMP_FETCH;
            end
          end else begin
            state_r <= DUMP_SEND;
          end
        end
        LOAD: begin
          if (loadBeat_s) begin
            if (idx_r == LAST_IDX) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        DONE: begin
          state_r         <= IDLE;
          busy_r          <= 1'b0;
          idx_r           <= IDX_ZERO;
          rfSrcRegister_r <= IDX_ZERO;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          idx_r       <= IDX_ZERO;
          dumpValid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign rfSrcRegister = rfSrcRegister_r;
  assign dumpValid     = dumpValid_r;
  assign dumpIndex     = dumpIndex_r;
  assign dumpData      = dumpData_r;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Self-checking bench for regfile_debug_port: a behavioural register file plus an
// expected-contents array drive randomized load/dump traffic against the DUT.
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        startDump, startLoad, dumpReady, loadValid;
  logic [31:0] loadData, rfReadData, rfWriteData, dumpData;
  logic [4:0]  rfSrcRegister, rfDesRegister, dumpIndex;
  logic        busy, done, rfWriteEnable, dumpValid, loadReady;

  logic [31:0] rf    [32] = '{default: 32'h0};
  logic [31:0] model [32] = '{default: 32'h0};
  logic [4:0]  wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  int          weRiseInReset = 0;
  int          nChecks = 0;
  int          nFails  = 0;

  regfile_debug_port dut (
    .clk(clk), .reset(reset), .startDump(startDump), .startLoad(startLoad),
    .busy(busy), .done(done), .rfSrcRegister(rfSrcRegister), .rfReadData(rfReadData),
    .rfWriteEnable(rfWriteEnable), .rfDesRegister(rfDesRegister), .rfWriteData(rfWriteData),
    .dumpValid(dumpValid), .dumpReady(dumpReady), .dumpIndex(dumpIndex), .dumpData(dumpData),
    .loadValid(loadValid), .loadReady(loadReady), .loadData(loadData)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write on the strobed clock edge, x0 hardwired.
  assign rfReadData = rf[rfSrcRegister];

  always @(posedge clk) begin
    if (rfWriteEnable === 1'b1) begin
      if (rfDesRegister != 5'd0) rf[rfDesRegister] <= rfWriteData;
      wrAddrQ.push_back(rfDesRegister);
      wrDataQ.push_back(rfWriteData);
    end
  end

  always @(posedge rfWriteEnable) begin
    if (reset) weRiseInReset <= weRiseInReset + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; startDump = 1'b0; startLoad = 1'b0; dumpReady = 1'b0;
    loadValid = 1'b0; loadData = 32'hDEAD_BEEF;
    #2;
    nChecks++;
    if ({busy, done, dumpValid, loadReady, rfWriteEnable, rfSrcRegister, rfDesRegister, dumpIndex} !== 20'h0 ||
        rfWriteData !== 32'h0 || dumpData !== 32'h0) begin
      nFails++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b wdata=%h ddata=%h, required all 0",
               busy, done, rfWriteEnable, rfWriteData, dumpData);
    end
    loadData = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    nChecks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nFails++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // mode 0: 0x100+i, mode 1: random, mode 2: 0x200+i. abortBeat>0 resets mid-cycle on that beat.
  task automatic test_load(input int mode, input int validPct, input int abortBeat);
    int beat = 1;
    int cycles = 0;
    int base = wrAddrQ.size();
    int riseBase = weRiseInReset;
    bit aborted = 1'b0;
    logic [31:0] word;
    startLoad = 1'b1;
    @(posedge clk); #1;
    startLoad = 1'b0;
    nChecks++;
    if (busy !== 1'b1 || loadReady !== 1'b1) begin
      nFails++;
      $display("FAIL load_start: busy=%b loadReady=%b, required 1 1", busy, loadReady);
    end
    while (beat <= 31 && cycles < 2000 && !aborted) begin
      loadValid = ($urandom_range(99) < validPct) ? 1'b1 : 1'b0;
      word = (mode == 0) ? 32'h100 + beat : (mode == 2) ? 32'h200 + beat : $urandom;
      loadData = word;
      #1;
      nChecks++;
      if (rfWriteEnable !== loadValid || (loadValid && (rfDesRegister !== 5'(beat) || rfWriteData !== word))) begin
        nFails++;
        $display("FAIL load_port beat %0d: we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                 beat, rfWriteEnable, rfDesRegister, rfWriteData, loadValid, beat, word);
      end
      if (beat == abortBeat && loadValid) begin
        #1 reset = 1'b1;
        #1;
        nChecks++;
        if ({busy, done, dumpValid, loadReady, rfWriteEnable, rfSrcRegister, rfDesRegister} !== 15'h0 ||
            rfWriteData !== 32'h0) begin
          nFails++;
          $display("FAIL reset_mid_load: busy=%b we=%b ready=%b addr=%0d wdata=%h, required all 0",
                   busy, rfWriteEnable, loadReady, rfDesRegister, rfWriteData);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        if (loadValid) begin
          model[beat] = word;
          beat++;
        end
        cycles++;
      end
    end
    loadValid = 1'b0;
    loadData = 32'h0;
    if (aborted) begin
      nChecks++;
      if (wrAddrQ.size() - base != abortBeat - 1 || weRiseInReset != riseBase) begin
        nFails++;
        $display("FAIL abort_writes: writes=%0d rises_in_reset=%0d, required %0d 0",
                 wrAddrQ.size() - base, weRiseInReset - riseBase, abortBeat - 1);
      end
      @(posedge clk); #1;
      nChecks++;
      if (busy !== 1'b0 || loadReady !== 1'b0) begin
        nFails++;
        $display("FAIL abort_idle: busy=%b loadReady=%b, required 0 0", busy, loadReady);
      end
    end else begin
      nChecks++;
      if (beat != 32 || done !== 1'b1) begin
        nFails++;
        $display("FAIL load_done: beats=%0d done=%b, required 31 beats and done=1", beat - 1, done);
      end
      @(posedge clk); #1;
      nChecks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        nFails++;
        $display("FAIL load_idle: done=%b busy=%b, required 0 0", done, busy);
      end
      nChecks++;
      if (wrAddrQ.size() - base != 31) begin
        nFails++;
        $display("FAIL load_count: strobes=%0d, required 31", wrAddrQ.size() - base);
      end
      for (int k = 0; k < 31 && base + k < wrAddrQ.size(); k++) begin
        nChecks++;
        if (wrAddrQ[base + k] !== 5'(k + 1) || wrDataQ[base + k] !== model[k + 1]) begin
          nFails++;
          $display("FAIL load_write %0d: addr=%0d data=%h, required addr=%0d data=%h",
                   k, wrAddrQ[base + k], wrDataQ[base + k], k + 1, model[k + 1]);
        end
      end
    end
    for (int r = 0; r < 32; r++) begin
      nChecks++;
      if (rf[r] !== model[r]) begin
        nFails++;
        $display("FAIL rf_contents x%0d: got %h, required %h", r, rf[r], model[r]);
      end
    end
  endtask

  task automatic test_dump(input bit alwaysReady, input bit randomStall, input int stallBeat,
                           input int stallLen, input bit dualStart, input int injectBeat);
    int base = wrAddrQ.size();
    int n, cycles;
    startDump = 1'b1;
    startLoad = dualStart;
    @(posedge clk); #1;
    startDump = 1'b0;
    startLoad = 1'b0;
    dumpReady = alwaysReady;
    for (int b = 0; b < 32; b++) begin
      cycles = 0;
      while (dumpValid !== 1'b1 && cycles < 50) begin
        @(posedge clk); #1;
        cycles++;
      end
      nChecks++;
      if (dumpValid !== 1'b1 || dumpIndex !== 5'(b) || dumpData !== model[b]) begin
        nFails++;
        $display("FAIL dump_beat %0d: valid=%b index=%0d data=%h, required 1 %0d %h",
                 b, dumpValid, dumpIndex, dumpData, b, model[b]);
      end
      n = (b == stallBeat) ? stallLen : (randomStall ? int'($urandom_range(3)) : 0);
      if (n > 0) begin
        dumpReady = 1'b0;
        repeat (n) begin
          @(posedge clk); #1;
          nChecks++;
          if (dumpValid !== 1'b1 || dumpIndex !== 5'(b) || dumpData !== model[b]) begin
            nFails++;
            $display("FAIL dump_hold %0d: valid=%b index=%0d data=%h, required 1 %0d %h",
                     b, dumpValid, dumpIndex, dumpData, b, model[b]);
          end
        end
      end
      dumpReady = 1'b1;
      if (b == injectBeat) startLoad = 1'b1;
      @(posedge clk); #1;
      startLoad = 1'b0;
      dumpReady = alwaysReady;
      nChecks++;
      if (dumpValid !== 1'b0) begin
        nFails++;
        $display("FAIL dump_consume %0d: valid=%b, required 0", b, dumpValid);
      end
    end
    nChecks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      nFails++;
      $display("FAIL dump_done: done=%b busy=%b, required 1 1", done, busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    nChecks++;
    if (done !== 1'b0 || busy !== 1'b0 || loadReady !== 1'b0) begin
      nFails++;
      $display("FAIL dump_idle: done=%b busy=%b loadReady=%b, required 0 0 0", done, busy, loadReady);
    end
    nChecks++;
    if (wrAddrQ.size() != base) begin
      nFails++;
      $display("FAIL dump_no_writes: strobes=%0d, required 0", wrAddrQ.size() - base);
    end
    dumpReady = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int cycles = 0;
    startDump = 1'b1;
    @(posedge clk); #1;
    startDump = 1'b0;
    dumpReady = 1'b0;
    while (dumpValid !== 1'b1 && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    #2 reset = 1'b1;
    #1;
    nChecks++;
    if (dumpValid !== 1'b0 || busy !== 1'b0 || dumpData !== 32'h0 || rfSrcRegister !== 5'd0) begin
      nFails++;
      $display("FAIL reset_mid_dump: valid=%b busy=%b data=%h src=%0d, required all 0",
               dumpValid, busy, dumpData, rfSrcRegister);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    nChecks++;
    if (busy !== 1'b0 || dumpValid !== 1'b0) begin
      nFails++;
      $display("FAIL dump_not_resumed: busy=%b valid=%b, required 0 0", busy, dumpValid);
    end
  endtask

  task automatic test_dual_start();
    test_dump(1'b1, 1'b0, -1, 0, 1'b1, -1);
  endtask

  task automatic test_start_while_busy();
    test_dump(1'b1, 1'b0, -1, 0, 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_load(0, 100, 0);
    test_dump(1'b1, 1'b0, -1, 0, 1'b0, -1);
    test_dump(1'b1, 1'b0, 5, 3, 1'b0, -1);
    test_dual_start();
    test_start_while_busy();
    test_load(1, 60, 0);
    test_dump(1'b0, 1'b1, -1, 0, 1'b0, -1);
    test_reset_mid_dump();
    test_load(2, 100, 10);
    test_dump(1'b1, 1'b1, -1, 0, 1'b0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
